// File: rtl/rom_load_ctrl.sv
// ROM download sequencer: steers the hps_io byte stream into four ROM regions,
// validates that the image is contiguous and complete, and owns the game core reset.
module rom_load_ctrl #(
    parameter logic [15:0] R0_END   = 16'h6000,
    parameter logic [15:0] R1_END   = 16'h7000,
    parameter logic [15:0] R2_END   = 16'h8000,
    parameter logic [15:0] R3_END   = 16'h8020,
    parameter logic [15:0] RST_HOLD = 16'd16
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        ext_reset,
    output logic [15:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic [3:0]  rom_we,
    output logic        core_reset,
    output logic        load_done,
    output logic        load_err,
    output logic [16:0] byte_cnt,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_LOAD = 2'd1,
        S_HOLD = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    state_t      state;
    logic [15:0] hold_cnt;
    logic [3:0]  dec_we;
    logic [15:0] dec_base;
    logic        dec_oob;
    logic        addr_gap;
    logic        go_load;

    // Handshake: ioctl_wr is a single-cycle strobe, valid only while ioctl_download
    // is high; there is no back-pressure, so every qualified strobe is consumed.
    always_comb begin
        dec_we   = 4'b0000;
        dec_base = 16'h0000;
        dec_oob  = 1'b0;
        if (ioctl_addr < {9'd0, R0_END}) begin
            dec_we = 4'b0001;
        end else if (ioctl_addr < {9'd0, R1_END}) begin
            dec_we   = 4'b0010;
            dec_base = R0_END;
        end else if (ioctl_addr < {9'd0, R2_END}) begin
            dec_we   = 4'b0100;
            dec_base = R1_END;
        end else if (ioctl_addr < {9'd0, R3_END}) begin
            dec_we   = 4'b1000;
            dec_base = R2_END;
        end else begin
            dec_oob = 1'b1;
        end
    end

    assign addr_gap  = (ioctl_addr != {8'd0, byte_cnt});
    // A new download pre-empts every other state, including a pending ext_reset.
    assign go_load   = ioctl_download && (state != S_LOAD);
    assign fsm_state = state;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_WAIT;
            hold_cnt   <= 16'd0;
            rom_addr   <= 16'd0;
            rom_data   <= 8'd0;
            rom_we     <= 4'b0000;
            core_reset <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            byte_cnt   <= 17'd0;
        end else begin
            rom_we <= 4'b0000;
            if (go_load) begin
                state      <= S_LOAD;
                byte_cnt   <= 17'd0;
                load_err   <= 1'b0;
                load_done  <= 1'b0;
                core_reset <= 1'b1;
            end else begin
                case (state)
                    S_WAIT: begin
                        core_reset <= 1'b1;
                    end
                    S_LOAD: begin
                        core_reset <= 1'b1;
                        if (!ioctl_download) begin
                            if (byte_cnt == {1'b0, R3_END} && !load_err) begin
                                state    <= S_HOLD;
                                hold_cnt <= RST_HOLD;
                            end else begin
                                load_err <= 1'b1;
                                state    <= S_WAIT;
                            end
                        end else if (ioctl_wr) begin
                            rom_data <= ioctl_dout;
                            rom_addr <= ioctl_addr[15:0] - dec_base;
                            rom_we   <= dec_we;
                            if (addr_gap || dec_oob) begin
                                load_err <= 1'b1;
                            end
                            if (byte_cnt != 17'h1FFFF) begin
                                byte_cnt <= byte_cnt + 17'd1;
                            end
                        end
                    end
                    S_HOLD: begin
                        core_reset <= 1'b1;
                        if (ext_reset) begin
                            hold_cnt <= RST_HOLD;
                        end else if (hold_cnt <= 16'd1) begin
                            // Release on the cycle the count reaches zero.
                            hold_cnt   <= 16'd0;
                            state      <= S_RUN;
                            core_reset <= 1'b0;
                            load_done  <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt - 16'd1;
                        end
                    end
                    S_RUN: begin
                        if (ext_reset) begin
                            state      <= S_HOLD;
                            hold_cnt   <= RST_HOLD;
                            core_reset <= 1'b1;
                        end else begin
                            core_reset <= 1'b0;
                        end
                    end
                    default: begin
                        state <= S_WAIT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rom_load_ctrl.sv
`timescale 1ns/1ps
// Directed bench for rom_load_ctrl: drives hps_io-style download streams and
// compares every ROM write against a queue of writes predicted from the region map.
module tb_rom_load_ctrl;

    localparam logic [1:0] ST_WAIT = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_RUN  = 2'd3;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = 25'd0;
    logic [7:0]  ioctl_dout = 8'd0;
    logic        ext_reset = 1'b0;

    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic [3:0]  rom_we;
    logic        core_reset;
    logic        load_done;
    logic        load_err;
    logic [16:0] byte_cnt;
    logic [1:0]  fsm_state;

    // Second, shrunken instance used for the truncated-image case.
    logic [15:0] s_rom_addr;
    logic [7:0]  s_rom_data;
    logic [3:0]  s_rom_we;
    logic        s_core_reset;
    logic        s_load_done;
    logic        s_load_err;
    logic [16:0] s_byte_cnt;
    logic [1:0]  s_fsm_state;

    int checks = 0;
    int errors = 0;
    int we_cnt [4] = '{0, 0, 0, 0};
    logic [27:0] exp_q [$];

    rom_load_ctrl u_dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ext_reset(ext_reset), .rom_addr(rom_addr), .rom_data(rom_data),
        .rom_we(rom_we), .core_reset(core_reset), .load_done(load_done),
        .load_err(load_err), .byte_cnt(byte_cnt), .fsm_state(fsm_state)
    );

    rom_load_ctrl #(
        .R0_END(16'h0010), .R1_END(16'h0018), .R2_END(16'h0020),
        .R3_END(16'h0024), .RST_HOLD(16'd16)
    ) u_small (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ext_reset(ext_reset), .rom_addr(s_rom_addr), .rom_data(s_rom_data),
        .rom_we(s_rom_we), .core_reset(s_core_reset), .load_done(s_load_done),
        .load_err(s_load_err), .byte_cnt(s_byte_cnt), .fsm_state(s_fsm_state)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    // Predicted write for one byte at the default region map: {we, offset, data}.
    function automatic logic [27:0] exp_word(input logic [24:0] a);
        logic [15:0] lo;
        lo = a[15:0];
        if (a < 25'h6000)      return {4'b0001, lo,            a[7:0]};
        else if (a < 25'h7000) return {4'b0010, lo - 16'h6000, a[7:0]};
        else if (a < 25'h8000) return {4'b0100, lo - 16'h7000, a[7:0]};
        else                   return {4'b1000, lo - 16'h8000, a[7:0]};
    endfunction

    // Scoreboard consumer: every ROM write must match the oldest predicted write.
    initial begin
        logic [27:0] w;
        forever begin
            @(negedge clk_sys);
            if (rom_we !== 4'b0000) begin
                if (exp_q.size() == 0) begin
                    check("rom_we_unexpected", 32'(rom_we), 32'd0);
                end else begin
                    w = exp_q.pop_front();
                    check("rom_write", {4'd0, rom_we, rom_addr, rom_data}, {4'd0, w});
                end
                for (int r = 0; r < 4; r++) begin
                    if (rom_we[r] === 1'b1) we_cnt[r]++;
                end
            end
        end
    end

    task automatic run_download(input int n, input bit skip, input bit probe, input bit drop_wr);
        logic [24:0] a;
        ioctl_download = 1'b1;
        step();
        check("entry_state", 32'(fsm_state), 32'(ST_LOAD));
        check("entry_core_reset", 32'(core_reset), 32'd1);
        check("entry_load_done", 32'(load_done), 32'd0);
        check("entry_byte_cnt", 32'(byte_cnt), 32'd0);
        for (int i = 0; i < n; i++) begin
            a = (skip && i >= 'h100) ? 25'(i + 1) : 25'(i);
            ioctl_wr   = 1'b1;
            ioctl_addr = a;
            ioctl_dout = a[7:0];
            if (a < 25'h8020) exp_q.push_back(exp_word(a));
            step();
            if (probe && a == 25'h7005) begin
                check("probe_7005_we", 32'(rom_we), 32'h4);
                check("probe_7005_addr", 32'(rom_addr), 32'h0005);
                check("probe_7005_data", 32'(rom_data), 32'h05);
            end
            if (a == 25'h8020) check("overrun_no_we", 32'(rom_we), 32'd0);
        end
        ioctl_wr = 1'b0;
        step();
        check("exp_q_drain", 32'(exp_q.size()), 32'd0);
        ioctl_download = 1'b0;
        ioctl_wr       = drop_wr;
        ioctl_addr     = 25'h0_8020;
        step();
        ioctl_wr = 1'b0;
    endtask

    initial begin
        int n;
        int base [4];
        bit ld_drop;

        // Reset values while reset_n is held low.
        #12;
        check("rst_core_reset", 32'(core_reset), 32'd1);
        check("rst_rom_we", 32'(rom_we), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_rom_data", 32'(rom_data), 32'd0);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_load_err", 32'(load_err), 32'd0);
        check("rst_byte_cnt", 32'(byte_cnt), 32'd0);
        check("rst_state", 32'(fsm_state), 32'(ST_WAIT));
        step();
        reset_n = 1'b1;

        // Idle after reset, including a stray strobe with download low.
        for (int i = 0; i < 40; i++) begin
            ioctl_wr   = (i == 5);
            ioctl_addr = 25'd0;
            step();
            check("idle_core_reset", 32'(core_reset), 32'd1);
        end
        check("idle_load_done", 32'(load_done), 32'd0);
        check("idle_byte_cnt", 32'(byte_cnt), 32'd0);
        check("idle_state", 32'(fsm_state), 32'(ST_WAIT));

        // Truncated image: one byte short of the end of the last region.
        run_download(32'h23, 1'b0, 1'b0, 1'b0);
        check("short_s_load_err", 32'(s_load_err), 32'd1);
        check("short_s_state", 32'(s_fsm_state), 32'(ST_WAIT));
        check("short_s_core_reset", 32'(s_core_reset), 32'd1);
        check("short_s_byte_cnt", 32'(s_byte_cnt), 32'h23);
        check("short_s_load_done", 32'(s_load_done), 32'd0);
        check("short_load_err", 32'(load_err), 32'd1);
        check("short_byte_cnt", 32'(byte_cnt), 32'h23);

        // Address gap at 0x0100.
        run_download(32'h200, 1'b1, 1'b0, 1'b0);
        check("gap_load_err", 32'(load_err), 32'd1);
        check("gap_state", 32'(fsm_state), 32'(ST_WAIT));
        check("gap_byte_cnt", 32'(byte_cnt), 32'h200);
        repeat (20) step();
        check("gap_core_reset", 32'(core_reset), 32'd1);
        check("gap_load_done", 32'(load_done), 32'd0);

        // Full good image; a strobe alongside the falling download must be ignored.
        for (int r = 0; r < 4; r++) base[r] = we_cnt[r];
        run_download(32'h8020, 1'b0, 1'b1, 1'b1);
        check("good_cnt_r0", 32'(we_cnt[0] - base[0]), 32'h6000);
        check("good_cnt_r1", 32'(we_cnt[1] - base[1]), 32'h1000);
        check("good_cnt_r2", 32'(we_cnt[2] - base[2]), 32'h1000);
        check("good_cnt_r3", 32'(we_cnt[3] - base[3]), 32'h20);
        check("good_byte_cnt", 32'(byte_cnt), 32'h8020);
        check("good_load_err", 32'(load_err), 32'd0);
        check("good_state_hold", 32'(fsm_state), 32'(ST_HOLD));
        check("good_core_reset_hold", 32'(core_reset), 32'd1);
        n = 0;
        while (core_reset === 1'b1 && n < 100) begin
            step();
            n++;
        end
        check("good_release_cycles", 32'(n), 32'd16);
        check("good_load_done", 32'(load_done), 32'd1);
        check("good_state_run", 32'(fsm_state), 32'(ST_RUN));

        // ext_reset held three cycles while running.
        repeat (5) step();
        ext_reset = 1'b1;
        n = 0;
        ld_drop = 1'b0;
        do begin
            step();
            n++;
            if (n == 1) check("ext_state_hold", 32'(fsm_state), 32'(ST_HOLD));
            if (n == 3) ext_reset = 1'b0;
            if (load_done !== 1'b1) ld_drop = 1'b1;
        end while (core_reset === 1'b1 && n < 100);
        check("ext_release_cycles", 32'(n), 32'd19);
        check("ext_load_done_kept", 32'(ld_drop), 32'd0);
        check("ext_state_run", 32'(fsm_state), 32'(ST_RUN));

        // Overrun by one byte at 0x8020, started from RUN.
        run_download(32'h8021, 1'b0, 1'b0, 1'b0);
        check("over_byte_cnt", 32'(byte_cnt), 32'h8021);
        check("over_load_err", 32'(load_err), 32'd1);
        check("over_state", 32'(fsm_state), 32'(ST_WAIT));
        check("over_core_reset", 32'(core_reset), 32'd1);
        check("over_load_done", 32'(load_done), 32'd0);

        // reset_n asserted mid-stream while a write strobe is visible.
        ioctl_download = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'(i);
            ioctl_dout = 8'(i + 8'h30);
            exp_q.push_back({4'b0001, 16'(i), 8'(i + 8'h30)});
            step();
        end
        check("abort_pre_we", 32'(rom_we), 32'h1);
        #5;
        reset_n = 1'b0;
        #1;
        check("abort_rom_we", 32'(rom_we), 32'd0);
        check("abort_rom_addr", 32'(rom_addr), 32'd0);
        check("abort_rom_data", 32'(rom_data), 32'd0);
        check("abort_core_reset", 32'(core_reset), 32'd1);
        check("abort_byte_cnt", 32'(byte_cnt), 32'd0);
        check("abort_state", 32'(fsm_state), 32'(ST_WAIT));
        check("abort_exp_q", 32'(exp_q.size()), 32'd0);
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        repeat (3) step();
        check("post_abort_state", 32'(fsm_state), 32'(ST_WAIT));
        check("post_abort_core_reset", 32'(core_reset), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rom_load_ctrl.md
Name: rom_load_ctrl

Overview:
- Sequences the HPS ROM download stream into the arcade core's ROM regions.
- Decodes each download byte into a one-hot region write strobe and checks that the stream is contiguous and complete.
- Owns the core reset: holds the core in reset until a valid image is loaded, then releases it after a fixed hold time.
- Sits between hps_io (ioctl_*) and the game top (dn_* / RESET).

Parameters:
- R0_END, 16'h6000: first address past region 0 (CPU program ROM).
- R1_END, 16'h7000: first address past region 1 (sound CPU ROM).
- R2_END, 16'h8000: first address past region 2 (tile/sprite ROM).
- R3_END, 16'h8020: first address past region 3 (colour PROM); also the total expected byte count.
- RST_HOLD, 16: number of clk_sys cycles the core reset is held after a good load or an external reset.

Ports:
- clk_sys, in, 1: system clock.
- reset_n, in, 1: asynchronous, active-low reset.
- ioctl_download, in, 1: download in progress.
- ioctl_wr, in, 1: byte strobe, one cycle.
- ioctl_addr, in, 25: byte address.
- ioctl_dout, in, 8: byte data.
- ext_reset, in, 1: OSD/button reset request, active high, level.
- rom_addr, out, 16: address offset within the selected region.
- rom_data, out, 8: registered byte.
- rom_we, out, 4: one-hot region write strobe.
- core_reset, out, 1: active-high reset to the game core.
- load_done, out, 1: a valid image is resident.
- load_err, out, 1: the last download was bad.
- byte_cnt, out, 17: bytes accepted in the current or last download.

Behaviour:
- States: WAIT, LOAD, HOLD, RUN.
- Async reset (reset_n=0):
  - State goes to WAIT.
  - Outputs: core_reset=1, rom_we=0, rom_addr=0, rom_data=0, load_done=0, load_err=0, byte_cnt=0, hold counter=0.
- WAIT:
  - core_reset=1.
  - ioctl_download=1 moves to LOAD.
- LOAD:
  - On entry: byte_cnt=0, load_err=0, load_done=0, core_reset=1.
  - Each ioctl_wr with ioctl_download=1 is one accepted byte.
  - One cycle later, rom_data=ioctl_dout and rom_addr=ioctl_addr minus the base of the decoded region.
  - rom_we decode:
    - region 0 if addr<R0_END;
    - region 1 if addr<R1_END;
    - region 2 if addr<R2_END;
    - region 3 if addr<R3_END.
    - rom_we is high for exactly that one cycle.
  - Latency from ioctl_wr to rom_we is 1 cycle. Back-to-back strobes give back-to-back rom_we.
  - Contiguity check: if ioctl_addr[24:0] != byte_cnt at the strobe, set load_err (sticky until the next LOAD entry).
  - Range check: if addr>=R3_END, set load_err and leave rom_we=0; the byte is still counted.
  - byte_cnt increments by 1 per accepted byte and saturates at 17'h1FFFF.
  - ioctl_wr with ioctl_download=0 is ignored in every state.
  - Falling edge of ioctl_download:
    - byte_cnt==R3_END and load_err=0: go to HOLD, load hold counter with RST_HOLD.
    - Otherwise: set load_err=1 and go to WAIT (core stays in reset).
  - A strobe in the same cycle download falls is ignored.
- HOLD:
  - core_reset=1; counter decrements each cycle.
  - At 0: go to RUN with load_done=1.
  - ioctl_download=1 goes to LOAD; this takes priority over the counter.
  - ext_reset=1 reloads the counter to RST_HOLD.
- RUN:
  - core_reset=0.
  - ext_reset=1 goes to HOLD with the counter reloaded; load_done stays 1.
  - ioctl_download=1 goes to LOAD; core_reset asserts in the same cycle as the state change.
- Simultaneous ext_reset and ioctl_download in any state: LOAD wins.
- reset_n assertion mid-LOAD aborts the load; rom_we drops asynchronously.

Test Plan:
1. reset_n low→high with no download → core_reset=1, load_done=0, rom_we=0 indefinitely.
2. Stream 0x8020 contiguous bytes with addr=data low byte, then drop download →
   - 0x6000 strobes on rom_we[0], 0x1000 on [1], 0x1000 on [2], 0x20 on [3];
   - addr 0x7005 gives rom_we=4'b0100 with rom_addr=0x0005, one cycle after ioctl_wr;
   - byte_cnt=0x8020;
   - core_reset falls exactly 16 cycles after HOLD entry; load_done=1.
3. Stream stops at 0x7FFF bytes → load_err=1, state WAIT, core_reset stays 1, byte_cnt=0x7FFF.
4. Skip address 0x0100 (jump from 0x00FF to 0x0101) → load_err=1 at the end; no release; a following good download clears load_err and releases reset.
5. In RUN, pulse ext_reset for 3 cycles → core_reset=1 for 3+16 cycles, load_done stays 1.
6. Write at addr 0x8020 (extra byte) → no rom_we, byte_cnt=0x8021, load_err=1; also assert reset_n mid-stream → all outputs return to reset values immediately.
